// File: rtl/demo_burst_ctrl_pkg.sv
// rtl/demo_burst_ctrl_pkg.sv - shared state encoding for the burst sequencer
package demo_burst_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACC  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FIN       = 3'd4
  } state_t;

endpackage

// File: rtl/demo_burst_ctrl_edge.sv
// rtl/demo_burst_ctrl_edge.sv - registered edge detector with selectable polarity
module demo_edge_detect #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic prev;

  // prev resets high so a level already low out of reset counts as a press
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      pulse <= FALLING ? (prev & ~din) : (~prev & din);
    end
  end

endmodule

// File: rtl/demo_burst_ctrl.sv
// rtl/demo_burst_ctrl.sv - burst sequencer moving a local byte buffer to/from consecutive bus addresses
module demo_burst_ctrl
  import demo_burst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int BUF_AW     = 5,
  parameter int TIMEOUT    = 4095
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [BUF_AW:0]       len,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  input  logic                  buf_we,
  input  logic [BUF_AW-1:0]     buf_waddr,
  input  logic [DATA_WIDTH-1:0] buf_wdata,
  input  logic [BUF_AW-1:0]     buf_raddr,
  output logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  dev_valid,
  output logic                  dev_mode,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic [DATA_WIDTH-1:0] dev_wdata,
  input  logic                  dev_ready,
  input  logic [DATA_WIDTH-1:0] dev_rdata
);

  localparam int DEPTH = 2 ** BUF_AW;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [BUF_AW:0]   LEN_MAX = (BUF_AW + 1)'(DEPTH);
  localparam logic [BUF_AW:0]   LEN_ONE = (BUF_AW + 1)'(1);
  localparam logic [BUF_AW-1:0] IDX_ONE = BUF_AW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(TIMEOUT - 1);

  state_t                state, state_nx;
  logic                  trig;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BUF_AW:0]       len_q, len_c;
  logic [BUF_AW-1:0]     idx;
  logic [CNT_W-1:0]      cnt;
  logic                  last_beat, tmo;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  demo_edge_detect #(.FALLING(1'b1)) u_start_edge (
    .clk   (clk),
    .rstn  (rstn),
    .din   (start),
    .pulse (trig)
  );

  assign len_c     = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_beat = ({1'b0, idx} == (len_q - LEN_ONE));
  // cnt holds the cycles already spent in this beat, so hitting the end value means TIMEOUT cycles elapse now
  assign tmo       = (cnt == CNT_END);
  assign buf_rdata = mem[buf_raddr];

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (trig) state_nx = (len_c == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE:     if (dev_ready) state_nx = ST_WAIT_ACC;
      ST_WAIT_ACC: begin
        if (!dev_ready) state_nx = ST_WAIT_DONE;
        else if (tmo)   state_nx = ST_FIN;
      end
      ST_WAIT_DONE: begin
        if (dev_ready) state_nx = last_beat ? ST_FIN : ST_ISSUE;
        else if (tmo)  state_nx = ST_FIN;
      end
      ST_FIN:       state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    done  = (state == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      cnt       <= '0;
      error     <= 1'b0;
      dev_valid <= 1'b0;
      dev_mode  <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            mode_q <= mode;
            base_q <= base_addr;
            len_q  <= len_c;
            idx    <= '0;
            error  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          cnt <= '0;
          if (dev_ready) begin
            dev_valid <= 1'b1;
            dev_mode  <= mode_q;
            dev_addr  <= base_q + ADDR_WIDTH'(idx);
            dev_wdata <= mem[idx];
          end
        end
        ST_WAIT_ACC: begin
          cnt <= cnt + CNT_ONE;
          if (!dev_ready) begin
            dev_valid <= 1'b0;
          end else if (tmo) begin
            dev_valid <= 1'b0;
            error     <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          cnt <= cnt + CNT_ONE;
          if (dev_ready) begin
            if (!last_beat) idx <= idx + IDX_ONE;
          end else if (tmo) begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Host writes only land while idle; a write in the trigger cycle still beats ISSUE's read of beat 0
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && buf_we)
      mem[buf_waddr] <= buf_wdata;
    else if (state == ST_WAIT_DONE && dev_ready && !mode_q)
      mem[idx] <= dev_rdata;
  end

endmodule

// File: tb/tb_demo_burst_ctrl.sv
// tb/tb_demo_burst_ctrl.sv - self-checking bench for demo_burst_ctrl with a slave model and buffer reference
module tb_demo_burst_ctrl;

  localparam int AW = 16, DW = 8, BAW = 5, TO = 16;

  logic clk = 1'b0;
  logic rstn, start, mode, ready, done, error, buf_we, dev_valid, dev_mode, dev_ready;
  logic [AW-1:0] base_addr, dev_addr;
  logic [BAW:0] len;
  logic [BAW-1:0] buf_waddr, buf_raddr;
  logic [DW-1:0] buf_wdata, buf_rdata, dev_wdata, dev_rdata;

  always #5 clk = ~clk;

  demo_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_AW(BAW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .base_addr(base_addr), .len(len),
    .ready(ready), .done(done), .error(error),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .dev_valid(dev_valid), .dev_mode(dev_mode), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ready(dev_ready), .dev_rdata(dev_rdata)
  );

  int checks = 0, failures = 0;
  logic [7:0]  ref_buf [32];
  logic [7:0]  slave_mem [65536];
  logic [15:0] q_addr [$];
  logic        q_mode [$];
  logic [7:0]  q_data [$];
  int          vr [$];
  int          slave_lat, hang_beat;
  bit          hang;
  int          r_dc, r_fv, r_ec, r_ndone;
  logic [7:0]  land_pre, land_post;

  typedef struct {
    bit          m;
    logic [15:0] b;
    logic [5:0]  l;
    int          beats;
    logic [15:0] first;
    logic [15:0] last;
    int          dc;
    int          fv;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave: registers the request one cycle, holds dev_ready low for a latency, then completes
  initial begin
    logic [15:0] a;
    logic m;
    logic [7:0] d;
    int l;
    dev_ready = 1'b1;
    dev_rdata = '0;
    for (int k = 0; k < 65536; k++) slave_mem[k] = 8'($urandom);
    forever begin
      @(posedge clk); #1;
      if (dev_valid && dev_ready) begin
        a = dev_addr; m = dev_mode; d = dev_wdata;
        q_addr.push_back(a); q_mode.push_back(m); q_data.push_back(d);
        @(posedge clk); #1;
        dev_ready = 1'b0;
        if (hang && (q_addr.size() - 1 == hang_beat)) begin
          while (hang) @(posedge clk);
          #1;
        end else begin
          l = (slave_lat > 0) ? slave_lat : int'($urandom_range(1, 4));
          repeat (l) @(posedge clk);
          #1;
          if (m) slave_mem[a] = d;
          else   dev_rdata = slave_mem[a];
        end
        dev_ready = 1'b1;
      end
    end
  end

  task automatic host_write(input int a, input logic [7:0] d);
    buf_we = 1'b1; buf_waddr = BAW'(a); buf_wdata = d;
    @(negedge clk);
    buf_we = 1'b0;
    ref_buf[a] = d;
  endtask

  // Cycle numbers count negedges after start is pulled low
  task automatic run_burst(input bit m, input logic [15:0] b, input logic [5:0] l,
                           input int wr_cyc, input logic [7:0] wr_data, input bit wr_commit);
    int cyc;
    bit rp, vprev;
    int land_r;
    q_addr.delete(); q_mode.delete(); q_data.delete(); vr.delete();
    mode = m; base_addr = b; len = l; buf_raddr = '0;
    r_dc = -1; r_fv = -1; r_ec = -1; r_ndone = 0; land_r = -1;
    rp = dev_ready; vprev = dev_valid;
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000 && !(r_dc >= 0 && cyc >= r_dc + 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) start = 1'b1;
      if (cyc == wr_cyc) begin
        buf_we = 1'b1; buf_waddr = '0; buf_wdata = wr_data;
      end else begin
        buf_we = 1'b0;
      end
      if (dev_valid && !vprev) begin
        vr.push_back(cyc);
        if (r_fv < 0) r_fv = cyc;
      end
      vprev = dev_valid;
      if (done) begin
        r_ndone++;
        if (r_dc < 0) r_dc = cyc;
      end
      if (error && r_ec < 0) r_ec = cyc;
      if (land_r < 0 && dev_ready && !rp) begin
        land_r = cyc; land_pre = buf_rdata;
      end else if (land_r >= 0 && cyc == land_r + 1) begin
        land_post = buf_rdata;
      end
      rp = dev_ready;
    end
    start = 1'b1;
    buf_we = 1'b0;
    check("done_seen", 32'(r_dc >= 0), 1);
    if (wr_commit) ref_buf[0] = wr_data;
  endtask

  task automatic check_model(input bit m, input logic [15:0] b, input logic [5:0] l);
    int n;
    n = (l > 6'd32) ? 32 : int'(l);
    check("beat_count", q_addr.size(), n);
    for (int k = 0; k < q_addr.size() && k < n; k++) begin
      check("beat_addr", q_addr[k], 16'(b + 16'(k)));
      check("beat_mode", q_mode[k], m);
      if (m) check("beat_wdata", q_data[k], ref_buf[k]);
    end
    if (!m) for (int k = 0; k < n; k++) ref_buf[k] = slave_mem[16'(b + 16'(k))];
    check("done_pulses", r_ndone, 1);
    check("error_clear", error, 0);
    for (int k = 0; k < 32; k++) begin
      buf_raddr = BAW'(k);
      #1;
      check("buffer", buf_rdata, ref_buf[k]);
    end
    @(negedge clk);
  endtask

  initial begin
    int n_rst_done;
    bit found;
    logic [5:0] rl;
    logic [15:0] rb;
    bit rm;

    vt[0] = '{1'b1, 16'hFFFE, 6'd3,  3,  16'hFFFE, 16'h0000, 14,  3};
    vt[1] = '{1'b0, 16'h0100, 6'd40, 32, 16'h0100, 16'h011F, 130, 3};
    vt[2] = '{1'b1, 16'h0000, 6'd0,  0,  16'h0000, 16'h0000, 2,   -1};
    vt[3] = '{1'b1, 16'h7FF0, 6'd32, 32, 16'h7FF0, 16'h800F, 130, 3};
    vt[4] = '{1'b0, 16'h00FF, 6'd1,  1,  16'h00FF, 16'h00FF, 6,   3};
    vt[5] = '{1'b1, 16'h4000, 6'd33, 32, 16'h4000, 16'h401F, 130, 3};
    vt[6] = '{1'b0, 16'h1234, 6'd2,  2,  16'h1234, 16'h1235, 10,  3};

    rstn = 1'b0; start = 1'b1; mode = 1'b0; base_addr = '0; len = '0;
    buf_we = 1'b0; buf_waddr = '0; buf_wdata = '0; buf_raddr = '0;
    hang = 1'b0; hang_beat = -1; slave_lat = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_dev_valid", dev_valid, 0);
    check("rst_dev_mode", dev_mode, 0);
    check("rst_dev_addr", dev_addr, 0);
    check("rst_dev_wdata", dev_wdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 32; k++) host_write(k, 8'($urandom));
    for (int k = 0; k < 4; k++) host_write(k, 8'(8'hA0 + k));

    run_burst(1'b1, 16'h8001, 6'd4, -1, 8'h00, 1'b0);
    check("wr_done_cyc", r_dc, 18);
    check("wr_first_valid_cyc", r_fv, 3);
    check_model(1'b1, 16'h8001, 6'd4);

    for (int k = 0; k < 4; k++) host_write(k, 8'h00);
    run_burst(1'b0, 16'h8001, 6'd4, -1, 8'h00, 1'b0);
    check("land_before", land_pre, 8'h00);
    check("land_after", land_post, 8'hA0);
    check_model(1'b0, 16'h8001, 6'd4);
    for (int k = 0; k < 4; k++) begin
      buf_raddr = BAW'(k);
      #1;
      check("readback", buf_rdata, 8'(8'hA0 + k));
    end
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      run_burst(vt[t].m, vt[t].b, vt[t].l, -1, 8'h00, 1'b0);
      check("vec_beats", q_addr.size(), vt[t].beats);
      check("vec_done_cyc", r_dc, vt[t].dc);
      check("vec_first_valid_cyc", r_fv, vt[t].fv);
      if (vt[t].beats > 0 && q_addr.size() > 0) begin
        check("vec_first_addr", q_addr[0], vt[t].first);
        check("vec_last_addr", q_addr[$], vt[t].last);
      end
      check_model(vt[t].m, vt[t].b, vt[t].l);
    end

    slave_lat = 0;
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) host_write(int'($urandom_range(0, 31)), 8'($urandom));
      rm = 1'($urandom);
      rb = 16'($urandom);
      rl = 6'($urandom_range(0, 40));
      run_burst(rm, rb, rl, (rl != 0) ? 4 : -1, ~ref_buf[0], 1'b0);
      check_model(rm, rb, rl);
    end

    slave_lat = 1;
    run_burst(1'b1, 16'h2000, 6'd2, 1, 8'h5A, 1'b1);
    if (q_data.size() > 0) check("trig_cycle_write", q_data[0], 8'h5A);
    check_model(1'b1, 16'h2000, 6'd2);

    hang_beat = 1; hang = 1'b1;
    run_burst(1'b1, 16'h3000, 6'd5, -1, 8'h00, 1'b0);
    check("to_beats_issued", q_addr.size(), 2);
    check("to_error", error, 1);
    check("to_done_pulses", r_ndone, 1);
    check("to_error_with_done", r_ec, r_dc);
    check("to_dev_valid", dev_valid, 0);
    check("to_valid_rises", vr.size(), 2);
    if (vr.size() >= 2) check("to_cycles", r_ec - vr[1], TO);
    hang = 1'b0; hang_beat = -1;
    repeat (4) @(negedge clk);

    slave_lat = 4;
    q_addr.delete(); q_mode.delete(); q_data.delete();
    mode = 1'b1; base_addr = 16'h1234; len = 6'd5;
    start = 1'b0;
    found = 1'b0;
    for (int c = 1; c < 200 && !found; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b1;
      if (q_addr.size() == 3 && !dev_valid) found = 1'b1;
    end
    start = 1'b1;
    check("rst_point_reached", found, 1);
    check("mid_dev_mode", dev_mode, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_dev_valid", dev_valid, 0);
    check("mid_rst_dev_mode", dev_mode, 0);
    check("mid_rst_dev_addr", dev_addr, 0);
    check("mid_rst_dev_wdata", dev_wdata, 0);
    rstn = 1'b1;
    n_rst_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_rst_done++;
    end
    check("mid_rst_no_done", n_rst_done, 0);
    slave_lat = 1;
    run_burst(1'b0, 16'h8001, 6'd4, -1, 8'h00, 1'b0);
    check("post_rst_done_cyc", r_dc, 18);
    check_model(1'b0, 16'h8001, 6'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demo_burst_ctrl.md
# demo_burst_ctrl

Burst master-side sequencer that drives the device port of the bus master (the `d1_*` interface of `top_with_bb_v1`), replacing the single-transfer demo FSM. On one start event it moves `len` consecutive bytes between a local register-file buffer and slave addresses `base_addr .. base_addr+len-1`, one bus transaction per byte. A per-beat timeout flags a stuck bus.

## Interface
- `ADDR_WIDTH`, 16: bus address width.
- `DATA_WIDTH`, 8: bus data width.
- `BUF_AW`, 5: buffer index width; depth is `2**BUF_AW`.
- `TIMEOUT`, 4095: maximum cycles per beat from `dev_valid` assertion to completion.
- `clk  in  1`: clock.
- `rstn  in  1`: reset; synchronous, active-low.
- `start  in  1`: active-low pushbutton level; a 1→0 edge, sampled against a registered copy that resets to 1, triggers a burst.
- `mode  in  1`: sampled at trigger; 1 = write (buffer→slave), 0 = read (slave→buffer).
- `base_addr  in  ADDR_WIDTH`: sampled at trigger.
- `len  in  BUF_AW+1`: beat count, sampled at trigger; values above `2**BUF_AW` are clamped to `2**BUF_AW`.
- `ready  out  1`: high only in IDLE.
- `done  out  1`: one-cycle pulse when a burst ends, whether OK or errored.
- `error  out  1`: sticky timeout flag; cleared at the next trigger.
- `buf_we  in  1`, `buf_waddr  in  BUF_AW`, `buf_wdata  in  DATA_WIDTH`: host write port. Ignored while busy.
- `buf_raddr  in  BUF_AW`, `buf_rdata  out  DATA_WIDTH`: host read port; combinational.
- `dev_valid  out  1`, `dev_mode  out  1`, `dev_addr  out  ADDR_WIDTH`, `dev_wdata  out  DATA_WIDTH`: request to the bus master device port.
- `dev_ready  in  1`: high when the bus master is idle; low while a transaction is in progress.
- `dev_rdata  in  DATA_WIDTH`: valid in the cycle `dev_ready` returns high.

## Operation
- States: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, FIN.
- **IDLE**
  - On trigger, latch `mode`, `base_addr`, clamped `len`; clear beat index `i` and `error`.
  - If `len`==0, go to FIN; otherwise go to ISSUE.
- **ISSUE**
  - Drive `dev_addr` = `base_addr + i` (modulo `2**ADDR_WIDTH`, wraps silently).
  - Drive `dev_mode` = latched mode and `dev_wdata` = `buf[i]`.
  - Assert `dev_valid`; go to WAIT_ACC.
- **WAIT_ACC**
  - Hold `dev_valid` and all request fields until `dev_ready` is sampled low, then deassert `dev_valid` and go to WAIT_DONE.
- **WAIT_DONE**
  - On `dev_ready` high: in read mode, write `buf[i]` ← `dev_rdata`.
  - If `i`==`len-1`, go to FIN; otherwise `i`++ and go to ISSUE.
- **Timeout**
  - Beat counter clears on entry to ISSUE and counts in WAIT_ACC and WAIT_DONE.
  - On reaching `TIMEOUT`: set `error`, drop `dev_valid`, go to FIN. The remaining beats are abandoned.
- **FIN**: pulse `done` for one cycle, return to IDLE.
- Triggers arriving while not in IDLE are dropped, not queued.
- `dev_valid` never asserts while `dev_ready` is already low on ISSUE entry; ISSUE stalls until `dev_ready` is high.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `error`=0, `dev_valid`=0, `dev_mode`=0, `dev_addr`=0, `dev_wdata`=0, `i`=0.
- Buffer contents are not reset.
- Trigger edge detected at cycle T means ISSUE in T+1 and `dev_valid` registered high in T+2.
- Minimum beat duration: 4 cycles (ISSUE, WAIT_ACC ×1, WAIT_DONE ×1, plus the transition cycle).
- Read-mode buffer write lands the cycle after `dev_ready` rises; visible on `buf_rdata` one cycle later.
- Reset mid-burst takes effect in the next cycle: outputs return to reset values, no `done` pulse is produced, and partial read data stays in the buffer.
- A host `buf_we` in the same cycle as the trigger is committed before beat 0 reads the buffer.

## Structure
- Shared package holds the state encoding constants (IDLE=0, ISSUE=1, WAIT_ACC=2, WAIT_DONE=3, FIN=4, 3-bit).
- The start edge detector is a natural sub-module, `demo_edge_detect`: parameterised polarity, reset value 1.
- Buffer is an inline register array, not BRAM, so `buf_rdata` is combinational.

## Test plan
- Write burst: buffer[0..3]=A0..A3, `base_addr`=0x8001, `len`=4, `mode`=1 → four transactions at 0x8001..0x8004 carrying A0..A3; `done` pulses once; `error`=0.
- Read-back: `mode`=0, same range → buffer[0..3]=A0..A3, each landing 1 cycle after `dev_ready` rises.
- Address wrap: `base_addr`=0xFFFE, `len`=3 → addresses 0xFFFE, 0xFFFF, 0x0000.
- Timeout: slave model holds `dev_ready` low forever after beat 1, `TIMEOUT`=16 → `error`=1 after 16 cycles; `dev_valid` drops; `done` pulses; beats 2+ are never issued.
- `len`=0 and `len`=40 (clamped to 32): `len`=0 gives `done` 2 cycles after trigger with no `dev_valid`; `len`=40 gives exactly 32 beats.
- `rstn` low during WAIT_DONE of beat 2 → next cycle shows all reset values; no `done`; a subsequent trigger runs normally.
